if_id_fifo: RTL and testbench

//  Decoupling buffer between the instruction fetch stage and the decode stage.

---
 rtl/if_id_fifo.sv | 135 +++++++++++++
 tb/tb_if_id_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// IF/ID decoupling FIFO: holds {pc+4, instruction} pairs between fetch and decode.
// Optional stall statistics counter is built when IFID_STATS_EN is defined.
module if_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_pc4,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_pc4,
    output logic [WIDTH-1:0]         out_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
`ifdef IFID_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] pc4_q   [DEPTH];
    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != {CW{1'b0}});
    assign count     = count_q;
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready & ~flush;

    // Head entry to decode; an empty buffer presents a zero NOP bubble.
    always_comb begin
        out_pc4   = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc4   = pc4_q[rd_ptr_q];
            out_instr = instr_q[rd_ptr_q];
        end else begin
            out_pc4   = '0;
            out_instr = '0;
        end
    end

    // Pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so no X can ever reach decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc4_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else if (push_s) begin
            pc4_q[wr_ptr_q]   <= in_pc4;
            instr_q[wr_ptr_q] <= in_instr;
        end
    end

`ifdef IFID_STATS_EN
    logic [15:0] stall_q, stall_d;

    assign stall_cnt = stall_q;

    // Saturating count of cycles where fetch is blocked by a full buffer.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// Scoreboard bench for if_id_fifo: a reference model queues accepted entries,
// a negedge monitor compares every DUT output against the queue head.
module tb_if_id_fifo;

    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             flush     = 1'b0;
    logic [WIDTH-1:0] in_pc4    = '0;
    logic [WIDTH-1:0] in_instr  = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc4;
    logic [WIDTH-1:0] out_instr;
    logic [1:0]       count;
`ifdef IFID_STATS_EN
    logic [15:0]      stall_cnt;
    logic [15:0]      stall_m;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [2*WIDTH-1:0] sb [$];
    int                 model_sz;
    int                 mon_sz;
    logic [2*WIDTH-1:0] mon_exp;

    if_id_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
`ifdef IFID_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: updates the expected contents on each edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sb.delete();
`ifdef IFID_STATS_EN
            stall_m = 16'd0;
`endif
        end else if (flush) begin
            sb.delete();
        end else begin
            model_sz = sb.size();
`ifdef IFID_STATS_EN
            if (in_valid && model_sz == DEPTH && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
            if (out_ready && model_sz != 0) void'(sb.pop_front());
            if (in_valid && model_sz != DEPTH) sb.push_back({in_pc4, in_instr});
        end
    end

    // Monitor: mid-cycle comparison of all outputs against the scoreboard.
    always @(negedge clock) begin
        if (reset_n) begin
            mon_sz  = sb.size();
            mon_exp = (mon_sz != 0) ? sb[0] : 64'd0;
            check("count",     64'(count),     64'(mon_sz));
            check("in_ready",  64'(in_ready),  64'(mon_sz != DEPTH));
            check("out_valid", 64'(out_valid), 64'(mon_sz != 0));
            check("out_data",  {out_pc4, out_instr}, mon_exp);
`ifdef IFID_STATS_EN
            check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
        end
    end

    // Drive one cycle of stimulus, return at the next posedge + 1.
    task automatic step(input logic iv, input logic [31:0] pc4, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc4    = pc4;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc4);
        return pc4 ^ 32'hA5A5_0000;
    endfunction

    initial begin
        #12;
        check("rst_count",     64'(count),     64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clock);
        #1;

        // Single pass.
        step(1'b1, 32'h4, 32'h8C22_0004, 1'b0, 1'b0);
        check("t2_out_valid", 64'(out_valid), 64'd1);
        check("t2_out_pc4",   64'(out_pc4),   64'h4);
        check("t2_out_instr", 64'(out_instr), 64'h8C22_0004);
        check("t2_count",     64'(count),     64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill, overflow attempt, drain.
        step(1'b1, 32'h4, ins_of(32'h4), 1'b0, 1'b0);
        step(1'b1, 32'h8, ins_of(32'h8), 1'b0, 1'b0);
        check("t3_count",    64'(count),    64'd2);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'hC, ins_of(32'hC), 1'b0, 1'b0);
        check("t3_head0", 64'(out_pc4), 64'h4);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("t3_head1", 64'(out_pc4), 64'h8);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("t3_empty_valid", 64'(out_valid), 64'd0);
        check("t3_empty_instr", 64'(out_instr), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming across pointer wrap.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 32'(4 * i), ins_of(32'(4 * i)), 1'b1, 1'b0);
            check("t4_stream_pc4", 64'(out_pc4), 64'(4 * i));
        end
        check("t4_count", 64'(count), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("t4_drained", 64'(count), 64'd0);

        // Flush with a competing push.
        step(1'b1, 32'h4, ins_of(32'h4), 1'b0, 1'b0);
        step(1'b1, 32'h8, ins_of(32'h8), 1'b0, 1'b0);
        step(1'b1, 32'h10, ins_of(32'h10), 1'b1, 1'b1);
        check("t5_count",     64'(count),     64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_instr", 64'(out_instr), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("t5_not_stored", 64'(count), 64'd0);

        // Asynchronous reset in the middle of a transfer.
        step(1'b1, 32'h20, ins_of(32'h20), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_pc4   = 32'h24;
        in_instr = ins_of(32'h24);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_count",     64'(count),     64'd0);
        check("t1_out_valid", 64'(out_valid), 64'd0);
        check("t1_out_instr", 64'(out_instr), 64'd0);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("t1_in_ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef IFID_STATS_EN
        // Stall counter: five blocked cycles, then saturation.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(1'b1, 32'h4, ins_of(32'h4), 1'b0, 1'b0);
        step(1'b1, 32'h8, ins_of(32'h8), 1'b0, 1'b0);
        repeat (5) step(1'b1, 32'hC, ins_of(32'hC), 1'b0, 1'b0);
        check("t6_stall5", 64'(stall_cnt), 64'd5);
        repeat (70000) step(1'b1, 32'hC, ins_of(32'hC), 1'b0, 1'b0);
        check("t6_stall_sat", 64'(stall_cnt), 64'hFFFF);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`endif

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
